// File: rtl/mdio_pkg.sv
// Shared constants for the MDIO op arbiter: FSM state encodings, PHY register
// addresses and the BMCR command words the control FSMs issue.
package mdio_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [4:0] REG_BMCR  = 5'h00;
    localparam logic [4:0] REG_BMSR  = 5'h01;
    localparam logic [4:0] REG_PHYSR = 5'h1A;

    localparam logic [15:0] BMCR_RST_AN  = 16'h9140;
    localparam logic [15:0] BMCR_100FD   = 16'h2100;
    localparam logic [15:0] BMCR_1000FD  = 16'h0140;

endpackage

// File: rtl/mdio_rr_pick.sv
// Combinational winner selection: optional fixed priority for requester 0,
// otherwise the first valid requester at or above the round-robin pointer.
module mdio_rr_pick
    import mdio_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter bit PRIO0   = 1'b1,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    localparam int PW = IDX_W + 1;

    logic [PW-1:0]    w_pos;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_pos   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        // Pointer plus offset never exceeds 2*NUM_REQ-2, so one subtraction wraps it.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, i_rr_ptr} + PW'(k);
            if (w_pos >= PW'(NUM_REQ)) begin
                w_pos = w_pos - PW'(NUM_REQ);
            end
            if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_pos[IDX_W-1:0];
            end
        end
        if (PRIO0 && i_req[0]) begin
            w_found = 1'b1;
            w_idx   = '0;
        end
    end

    always_comb begin
        o_grant = '0;
        if (w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule

// File: rtl/mdio_op_arbiter.sv
// Shares one MDIO master op port among NUM_REQ requesters, one op in flight,
// returning read data or a timeout error to the requester that won the grant.
module mdio_op_arbiter
    import mdio_pkg::*;
#(
    parameter int          NUM_REQ     = 3,
    parameter bit          PRIO0       = 1'b1,
    parameter logic [23:0] TIMEOUT_CNT = 24'd200000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_rh_wl,
    input  logic [NUM_REQ*5-1:0]  req_addr,
    input  logic [NUM_REQ*16-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_rd_data,
    output logic                  rsp_rd_ack,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  op_exec,
    output logic                  op_rh_wl,
    output logic [4:0]            op_addr,
    output logic [15:0]           op_wr_data,
    input  logic                  op_done,
    input  logic [15:0]           op_rd_data,
    input  logic                  op_rd_ack
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [23:0]      r_cnt;
    logic             r_op_rh_wl;
    logic [4:0]       r_op_addr;
    logic [15:0]      r_op_wr_data;
    logic [15:0]      r_rsp_rd_data;
    logic             r_rsp_rd_ack;
    logic             r_rsp_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic               w_start;
    logic               w_timeout;

    mdio_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PRIO0   (PRIO0)
    ) u_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_start   = (r_state == ST_IDLE) && w_any && !rst;
    assign w_timeout = (r_cnt == TIMEOUT_CNT - 24'd1);

    assign req_ready   = w_start ? w_grant : '0;
    assign busy        = (r_state != ST_IDLE);
    assign op_exec     = (r_state == ST_ISSUE);
    assign op_rh_wl    = r_op_rh_wl;
    assign op_addr     = r_op_addr;
    assign op_wr_data  = r_op_wr_data;
    assign rsp_rd_data = r_rsp_rd_data;
    assign rsp_rd_ack  = r_rsp_rd_ack;
    assign rsp_err     = r_rsp_err;

    always_comb begin
        rsp_valid = '0;
        if (r_state == ST_RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_cnt         <= '0;
            r_op_rh_wl    <= 1'b0;
            r_op_addr     <= '0;
            r_op_wr_data  <= '0;
            r_rsp_rd_data <= '0;
            r_rsp_rd_ack  <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_owner      <= w_idx;
                        r_op_rh_wl   <= req_rh_wl[w_idx];
                        r_op_addr    <= req_addr[5*w_idx +: 5];
                        r_op_wr_data <= req_wr_data[16*w_idx +: 16];
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the expiry cycle is still honoured as a normal response.
                    if (op_done) begin
                        r_rsp_rd_data <= r_op_rh_wl ? op_rd_data : 16'h0000;
                        r_rsp_rd_ack  <= op_rd_ack;
                        r_rsp_err     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_rd_data <= 16'h0000;
                        r_rsp_rd_ack  <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_state       <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                ST_RESP: begin
                    r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_op_arbiter.sv
// Bench for mdio_op_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a timestamp-based transaction model.
module tb_mdio_op_arbiter;
    import mdio_pkg::*;

    localparam int N  = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_rh_wl = '0;
    logic [N*5-1:0]  req_addr = '0;
    logic [N*16-1:0] req_wr_data = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_rd_data;
    logic            rsp_rd_ack;
    logic            rsp_err;
    logic            busy;
    logic            op_exec;
    logic            op_rh_wl;
    logic [4:0]      op_addr;
    logic [15:0]     op_wr_data;
    logic            op_done = 1'b0;
    logic [15:0]     op_rd_data = '0;
    logic            op_rd_ack = 1'b0;

    mdio_op_arbiter #(
        .NUM_REQ     (N),
        .PRIO0       (1'b1),
        .TIMEOUT_CNT (24'(TO))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rh_wl   (req_rh_wl),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rd_data (rsp_rd_data),
        .rsp_rd_ack  (rsp_rd_ack),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .op_exec     (op_exec),
        .op_rh_wl    (op_rh_wl),
        .op_addr     (op_addr),
        .op_wr_data  (op_wr_data),
        .op_done     (op_done),
        .op_rd_data  (op_rd_data),
        .op_rd_ack   (op_rd_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Master config: latency in cycles after op_exec, -1 means never complete.
    int          m_lat  = 2;
    bit          m_rand = 1'b0;
    logic [15:0] m_data = '0;
    logic        m_ack  = 1'b0;

    logic         s_exec  = 1'b0;
    logic         s_rst   = 1'b1;
    logic [N-1:0] s_ready = '0;

    // Transaction model state (cycle timestamps rather than FSM states)
    bit          m_init = 1'b0;
    bit          m_idle = 1'b1;
    bit          m_rspset = 1'b0;
    int          cyc = 0;
    int          t_g = 0;
    int          t_rsp = 0;
    int          m_ptr = 0;
    int          m_owner = 0;
    logic        e_rh = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [15:0] e_wd = '0;
    logic [15:0] e_rdata = '0;
    logic        e_ack = 1'b0;
    logic        e_err = 1'b0;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        if (v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        logic         e_exec;
        logic         e_busy;
        int           g;
        e_ready = '0;
        e_rsp   = '0;
        e_exec  = 1'b0;
        e_busy  = !m_idle;
        g       = -1;
        if (m_idle) begin
            if (!rst && (|req_valid)) begin
                g = pick(req_valid, m_ptr);
                e_ready[g] = 1'b1;
            end
        end else begin
            e_exec = (cyc == t_g + 1);
            if (m_rspset && cyc == t_rsp) e_rsp[m_owner] = 1'b1;
        end
        if (m_init) begin
            chk("req_ready",   32'(req_ready),   32'(e_ready));
            chk("rsp_valid",   32'(rsp_valid),   32'(e_rsp));
            chk("op_exec",     32'(op_exec),     32'(e_exec));
            chk("busy",        32'(busy),        32'(e_busy));
            chk("op_rh_wl",    32'(op_rh_wl),    32'(e_rh));
            chk("op_addr",     32'(op_addr),     32'(e_addr));
            chk("op_wr_data",  32'(op_wr_data),  32'(e_wd));
            chk("rsp_rd_data", 32'(rsp_rd_data), 32'(e_rdata));
            chk("rsp_rd_ack",  32'(rsp_rd_ack),  32'(e_ack));
            chk("rsp_err",     32'(rsp_err),     32'(e_err));
        end
        s_exec  = op_exec;
        s_ready = req_ready;
        s_rst   = rst;
        if (rst) begin
            m_init = 1'b1; m_idle = 1'b1; m_rspset = 1'b0; m_ptr = 0;
            e_rh = 1'b0; e_addr = '0; e_wd = '0; e_rdata = '0; e_ack = 1'b0; e_err = 1'b0;
        end else if (g >= 0) begin
            m_idle = 1'b0; m_owner = g; t_g = cyc; m_rspset = 1'b0;
            e_rh   = req_rh_wl[g];
            e_addr = req_addr[5*g +: 5];
            e_wd   = req_wr_data[16*g +: 16];
        end else if (!m_idle) begin
            if (m_rspset && cyc == t_rsp) begin
                m_idle = 1'b1;
                m_ptr  = (m_owner + 1) % N;
            end else if (!m_rspset && cyc >= t_g + 2) begin
                if (op_done) begin
                    m_rspset = 1'b1; t_rsp = cyc + 1;
                    e_rdata = e_rh ? op_rd_data : 16'h0000;
                    e_ack = op_rd_ack; e_err = 1'b0;
                end else if (cyc == t_g + 1 + TO) begin
                    m_rspset = 1'b1; t_rsp = cyc + 1;
                    e_rdata = 16'h0000; e_ack = 1'b1; e_err = 1'b1;
                end
            end
        end
        cyc++;
    end

    int          mst_cnt = 0;
    bit          mst_active = 1'b0;
    logic [15:0] mst_d = '0;
    logic        mst_a = 1'b0;

    always @(posedge clk) begin : master
        #1;
        op_done    = 1'b0;
        op_rd_data = 16'($urandom);
        op_rd_ack  = 1'($urandom);
        if (s_rst) begin
            mst_active = 1'b0;
        end else begin
            if (s_exec) begin
                if (m_rand) begin
                    mst_cnt = ($urandom % 8 == 0) ? -1 : int'($urandom_range(0, 17));
                    mst_d   = 16'($urandom);
                    mst_a   = 1'($urandom);
                end else begin
                    mst_cnt = m_lat;
                    mst_d   = m_data;
                    mst_a   = m_ack;
                end
                mst_active = (mst_cnt >= 0);
            end
            if (mst_active) begin
                if (mst_cnt == 0) begin
                    op_done = 1'b1; op_rd_data = mst_d; op_rd_ack = mst_a;
                    mst_active = 1'b0;
                end else begin
                    mst_cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic rh, input logic [4:0] a,
                         input logic [15:0] d, input string nm);
        bit got = 1'b0;
        req_rh_wl[i] = rh;
        req_addr[5*i +: 5] = a;
        req_wr_data[16*i +: 16] = d;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        chk({nm, "_grant"}, 32'(got), 1);
        tick();
        req_valid[i] = 1'b0;
        @(negedge clk);
        chk({nm, "_exec"}, 32'(op_exec), 1);
        chk({nm, "_addr"}, 32'(op_addr), 32'(a));
    endtask

    task automatic wait_rsp(input string nm, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (|rsp_valid) got = 1'b1;
        end
        chk({nm, "_rsp_seen"}, 32'(got), 1);
    endtask

    task automatic wait_ready(output int idx);
        bit got = 1'b0;
        idx = -1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (|req_ready) begin
                got = 1'b1;
                for (int j = 0; j < N; j++) if (req_ready[j]) idx = j;
            end
        end
    endtask

    task automatic new_fields(input int i);
        req_rh_wl[i] = 1'($urandom);
        req_addr[5*i +: 5] = 5'($urandom);
        req_wr_data[16*i +: 16] = 16'($urandom);
    endtask

    initial begin
        int lat;
        int idx;
        int order[4];
        int cnt;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_addr", 32'(op_addr), 0);
        chk("rst_rsp_data", 32'(rsp_rd_data), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);

        // Single read from requester 1
        tick();
        m_lat = 3; m_data = 16'h796D; m_ack = 1'b0;
        issue(1, 1'b1, REG_BMSR, 16'h0000, "rd");
        wait_rsp("rd", lat);
        chk("rd_lat", 32'(lat), 5);
        chk("rd_vld", 32'(rsp_valid), 'b010);
        chk("rd_data", 32'(rsp_rd_data), 'h796D);
        chk("rd_err", 32'(rsp_err), 0);
        chk("rd_ack", 32'(rsp_rd_ack), 0);

        // Write of the reset+AN command word
        tick();
        m_lat = 5; m_data = 16'hFFFF; m_ack = 1'b0;
        issue(0, 1'b0, REG_BMCR, BMCR_RST_AN, "wr");
        chk("wr_wdata_exec", 32'(op_wr_data), 'h9140);
        wait_rsp("wr", lat);
        chk("wr_vld", 32'(rsp_valid), 'b001);
        chk("wr_rdata", 32'(rsp_rd_data), 0);
        chk("wr_wdata_done", 32'(op_wr_data), 'h9140);

        // Contention between requesters 1 and 2 from rr_ptr=0
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        m_lat = 1;
        req_rh_wl[1] = 1'b1; req_addr[5 +: 5] = REG_BMSR;
        req_rh_wl[2] = 1'b1; req_addr[10 +: 5] = REG_PHYSR;
        req_valid[1] = 1'b1; req_valid[2] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ready(idx);
            order[n] = idx;
        end
        tick();
        req_valid = '0;
        wait_rsp("cont", lat);
        chk("cont_g0", 32'(order[0]), 1);
        chk("cont_g1", 32'(order[1]), 2);
        chk("cont_g2", 32'(order[2]), 1);
        chk("cont_g3", 32'(order[3]), 2);

        // Requester 0 priority over a waiting requester 2
        tick();
        req_valid[0] = 1'b1; req_valid[2] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_ready(idx);
            chk("prio_win0", 32'(idx), 0);
            tick();
            req_valid[0] = 1'b0;
            wait_rsp("prio", lat);
            tick();
            if (r < 2) req_valid[0] = 1'b1;
        end
        wait_ready(idx);
        chk("prio_then2", 32'(idx), 2);
        tick();
        req_valid[2] = 1'b0;
        wait_rsp("prio2", lat);
        chk("prio2_vld", 32'(rsp_valid), 'b100);

        // Timeout with no completion
        tick();
        m_lat = -1;
        issue(2, 1'b1, REG_PHYSR, 16'h0000, "to");
        wait_rsp("to", lat);
        chk("to_wait_cycles", 32'(lat - 1), 16);
        chk("to_vld", 32'(rsp_valid), 'b100);
        chk("to_err", 32'(rsp_err), 1);
        chk("to_ack", 32'(rsp_rd_ack), 1);
        chk("to_data", 32'(rsp_rd_data), 0);

        // Completion in the expiry cycle
        tick();
        m_lat = 15; m_data = 16'hA5C3; m_ack = 1'b0;
        issue(1, 1'b1, REG_BMSR, 16'h0000, "col");
        wait_rsp("col", lat);
        chk("col_lat", 32'(lat), 17);
        chk("col_err", 32'(rsp_err), 0);
        chk("col_data", 32'(rsp_rd_data), 'hA5C3);
        chk("col_ack", 32'(rsp_rd_ack), 0);

        // Reset while waiting on the master
        tick();
        m_lat = -1;
        issue(1, 1'b1, REG_BMSR, 16'h0000, "rw");
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rw_busy", 32'(busy), 0);
        chk("rw_addr", 32'(op_addr), 0);
        chk("rw_data", 32'(rsp_rd_data), 0);
        chk("rw_vld", 32'(rsp_valid), 0);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (|rsp_valid) cnt++;
        end
        chk("rw_no_rsp", 32'(cnt), 0);

        // Randomized traffic with random master latency and timeouts
        m_rand = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            tick();
            if (n == 700) rst = 1'b1;
            if (n == 702) rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && s_ready[i]) begin
                    req_valid[i] = 1'($urandom);
                    new_fields(i);
                end else if (!req_valid[i]) begin
                    if ($urandom % 4 == 0) begin
                        req_valid[i] = 1'b1;
                        new_fields(i);
                    end
                end else if ($urandom % 40 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        tick();
        req_valid = '0;
        cnt = 0;
        for (int k = 0; k < 60 && busy; k++) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
